// File: rtl/rv32i_types.sv
// Shared RV32 execute-stage types.
// Holds the M-extension operation encoding (funct3) and the fixed latency
// of the iterative multiply/divide sequencer.
package rv32i_types;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_ops;

  // start edge to done cycle, in clocks
  localparam int MULDIV_LAT   = 35;
  localparam int MULDIV_ITERS = 32;

  // two's-complement magnitude when neg is set
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply / restoring divide loop.
// Ports:
//   acc      in  64  {hi, lo}: mul = {partial sum, multiplier}; div = {rem, quot}
//   opnd     in  32  multiplicand (mul) or divisor (div), magnitude
//   is_div   in  1   selects divide step
//   acc_next out 64  accumulator after this iteration
// A single 33-bit adder (with carry out) serves both modes.
import rv32i_types::*;

module muldiv_step (
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  input  logic        is_div,
  output logic [63:0] acc_next
);

  logic [32:0] add_x, add_y;
  logic        add_cin;
  logic [33:0] sum;
  logic [32:0] shifted;

  // remainder shifted left with the next dividend bit; 33 bits since it can
  // reach up to twice the divisor
  assign shifted = {acc[63:32], acc[31]};
  assign sum     = {1'b0, add_x} + {1'b0, add_y} + {33'd0, add_cin};

  always_comb begin
    add_x    = {1'b0, acc[63:32]};
    add_y    = {1'b0, opnd};
    add_cin  = 1'b0;
    acc_next = acc;
    if (is_div) begin
      // shifted - divisor; carry out set means no borrow (result >= 0)
      add_x   = shifted;
      add_y   = ~{1'b0, opnd};
      add_cin = 1'b1;
      if (sum[33])
        acc_next = {sum[31:0], acc[30:0], 1'b1};
      else
        acc_next = {shifted[31:0], acc[30:0], 1'b0};
    end else begin
      // the 33rd sum bit is the carry that moves down into bit 63
      if (acc[0])
        acc_next = {sum[32:0], acc[31:1]};
      else
        acc_next = {1'b0, acc[63:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (EX stage).
// Ports:
//   clk, rst      clock, async active-high reset
//   start         request, taken only when busy=0
//   op            muldiv_ops (funct3)
//   a, b          rs1 / rs2 operands, sampled with start
//   flush         abort current op, back to IDLE without done
//   busy          stall request to the pipeline (PREP, CALC, FIX)
//   done          one-cycle pulse, result valid
//   result        final value, held until the next accepted start
// Fixed 35-cycle path for every op including div-by-zero and overflow.
import rv32i_types::*;

module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  muldiv_ops   op_q;
  logic [31:0] a_q, b_q;   // original operands, kept for the special cases
  logic        sa, sb;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic [63:0] acc_nxt;

  muldiv_step u_step (
    .acc      (acc),
    .opnd     (opnd),
    .is_div   (op_q[2]),
    .acc_next (acc_nxt)
  );

  // sign flags, evaluated during PREP from the latched operands
  logic sa_n, sb_n;
  assign sa_n = a_q[31] & (op_q == MD_MULH || op_q == MD_MULHSU ||
                           op_q == MD_DIV  || op_q == MD_REM);
  assign sb_n = b_q[31] & (op_q == MD_MULH || op_q == MD_DIV || op_q == MD_REM);

  // result selection and sign fix-up
  logic [63:0] prod_s;
  logic [31:0] quot, rem, fix_val;
  logic        b_zero, ovf;

  assign b_zero = (b_q == 32'd0);
  assign ovf    = (op_q == MD_DIV || op_q == MD_REM) &&
                  (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign prod_s = (sa ^ sb) ? (~acc + 64'd1) : acc;
  assign quot   = acc[31:0];
  assign rem    = acc[63:32];

  always_comb begin
    fix_val = prod_s[31:0];
    case (op_q)
      MD_MUL:                       fix_val = prod_s[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod_s[63:32];
      MD_DIV, MD_DIVU:
        if (b_zero)   fix_val = 32'hFFFF_FFFF;
        else if (ovf) fix_val = 32'h8000_0000;
        else          fix_val = mag32(quot, sa ^ sb);
      MD_REM, MD_REMU:
        if (b_zero)   fix_val = a_q;
        else if (ovf) fix_val = 32'd0;
        else          fix_val = mag32(rem, sa);
      default:                      fix_val = prod_s[31:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      op_q   <= MD_MUL;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      acc    <= 64'd0;
      opnd   <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= muldiv_ops'(op);
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= S_PREP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PREP: begin
          sa    <= sa_n;
          sb    <= sb_n;
          // high half is the running sum / remainder; low half carries the
          // multiplier or dividend magnitude and shifts out as the loop runs
          acc   <= {32'd0, mag32(a_q, sa_n)};
          opnd  <= mag32(b_q, sb_n);
          cnt   <= 5'd0;
          state <= S_CALC;
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(MULDIV_ITERS - 1)) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_val;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, randomized ops against a
// plain-arithmetic reference, and hand-written handshake/flush/reset sequences.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int vec = 0;
  int err = 0;

  muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op_i),
    .a      (a_i),
    .b      (b_i),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference: RV32M semantics from 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int     ai, bi;
    longint as_, bs, au, bu;
    logic [63:0] p;
    ai = a; bi = b;
    as_ = ai; bs = bi;
    au = {32'd0, a}; bu = {32'd0, b};
    case (op)
      3'd0: begin p = as_ * bs; return p[31:0];  end
      3'd1: begin p = as_ * bs; return p[63:32]; end
      3'd2: begin p = as_ * bu; return p[63:32]; end
      3'd3: begin p = au * bu;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ai / bi;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ai % bi;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // issue one op from a safe point (#1 after an edge); returns result and
  // number of edges from the accepting edge to the done cycle
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    op_i = op; a_i = a; b_i = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  vec_t        tbl[$];
  logic [31:0] res, prev;
  int          lat, seen;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op_i = 3'd0; a_i = 32'd0; b_i = 32'd0;

    tbl.push_back('{3'd0, 32'd7,           32'hFFFF_FFFD, 32'hFFFF_FFEB});
    tbl.push_back('{3'd3, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFE});
    tbl.push_back('{3'd1, 32'h8000_0000,   32'h8000_0000, 32'h4000_0000});
    tbl.push_back('{3'd2, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFF});
    tbl.push_back('{3'd1, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'h0000_0000});
    tbl.push_back('{3'd4, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD});
    tbl.push_back('{3'd6, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF});
    tbl.push_back('{3'd5, 32'd100,         32'd7,         32'd14});
    tbl.push_back('{3'd7, 32'd100,         32'd7,         32'd2});
    tbl.push_back('{3'd4, 32'd5,           32'd0,         32'hFFFF_FFFF});
    tbl.push_back('{3'd6, 32'd5,           32'd0,         32'd5});
    tbl.push_back('{3'd5, 32'd5,           32'd0,         32'hFFFF_FFFF});
    tbl.push_back('{3'd7, 32'hFFFF_FFF9,   32'd0,         32'hFFFF_FFF9});
    tbl.push_back('{3'd4, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000});
    tbl.push_back('{3'd6, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0});
    tbl.push_back('{3'd5, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0});

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed table, issued back-to-back in each done cycle
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      check($sformatf("tbl%0d_lat", i), lat, 35);
      check($sformatf("tbl%0d_res", i), res, tbl[i].exp);
      check($sformatf("tbl%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    check("done_single_pulse", {31'd0, done}, 32'd0);

    // randomized ops against the reference
    for (int i = 0; i < 48; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, res, lat);
      check($sformatf("rnd%0d_lat op=%0d", i, rop), lat, 35);
      check($sformatf("rnd%0d op=%0d a=%h b=%h", i, rop, ra, rb), res, model(rop, ra, rb));
    end
    @(posedge clk); #1;

    // start pulsed mid-operation (cycle 10) is ignored
    op_i = 3'd5; a_i = 32'd1000; b_i = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    repeat (9) begin @(posedge clk); #1; lat++; end
    op_i = 3'd0; a_i = 32'd3; b_i = 32'd5; start = 1'b1;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    check("midstart_lat", lat, 35);
    check("midstart_res", result, 32'd142);
    prev = result;
    @(posedge clk); #1;

    // flush in CALC iteration 5: IDLE next cycle, no done, result held
    op_i = 3'd0; a_i = 32'd7; b_i = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result", result, prev);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    check("flush_no_done", seen, 0);

    // flush and start together: request dropped
    op_i = 3'd0; a_i = 32'd2; b_i = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    check("flush_start_no_done", seen, 0);

    // async reset mid-CALC
    op_i = 3'd3; a_i = 32'd12345; b_i = 32'd678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'd0, 32'd12345, 32'd678, res, lat);
    check("post_rst_lat", lat, 35);
    check("post_rst_res", res, 32'd8369910);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
